// File: rtl/cpu_pkg.sv
// Shared types for the operation sequencer: register-file geometry, opcodes,
// sequencer states and the queued instruction word.
package cpu_pkg;

  localparam int NREG      = 8;
  localparam int REG_IDX_W = $clog2(NREG);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    FU_ADD     = 2'd0,
    FU_MUL     = 2'd1,
    FU_NTT     = 2'd2,
    FU_ILLEGAL = 2'd3
  } fu_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RF   = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  typedef struct packed {
    fu_e      op;
    reg_idx_t src0;
    reg_idx_t src1;
    reg_idx_t dst;
  } instr_t;

  // Two-operand units read the second source; the NTT unit is unary.
  function automatic logic uses_src1(input fu_e op);
    return (op == FU_ADD) || (op == FU_MUL);
  endfunction

endpackage

// File: rtl/op_fifo.sv
// Instruction queue: power-of-two depth, pointers carry one extra wrap bit so
// full and empty are distinguishable. Push is accepted when full if a pop happens.
module op_fifo #(
  parameter int  QDEPTH  = 4,
  parameter type instr_t = cpu_pkg::instr_t
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  instr_t push_data,
  input  logic   pop,
  output instr_t pop_data,
  output logic   full,
  output logic   empty
);

  localparam int             PTR_W   = $clog2(QDEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  instr_t         mem_q [QDEPTH];
  logic           do_push;
  logic           do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after it is written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/op_sequencer.sv
// Queues instructions and issues them one at a time to the register file.
// Define OP_SEQ_TIMEOUT_EN to add the WAIT_DONE watchdog and err_timeout port.
module op_sequencer
  import cpu_pkg::*;
#(
  parameter int QDEPTH         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [1:0]           instr_op,
  input  logic [REG_IDX_W-1:0] instr_src0,
  input  logic [REG_IDX_W-1:0] instr_src1,
  input  logic [REG_IDX_W-1:0] instr_dst,
  input  logic                 register_file_ready,
  input  logic                 destination_valid,
  input  logic                 destination_last,
  output logic                 start_operation,
  output logic                 use_source1,
  output logic [1:0]           fu_sel,
  output logic [REG_IDX_W-1:0] source0_register_index,
  output logic [REG_IDX_W-1:0] source1_register_index,
  output logic [REG_IDX_W-1:0] destination_register_index,
  output logic                 busy,
  output logic                 op_done,
  output logic                 err_illegal,
`ifdef OP_SEQ_TIMEOUT_EN
  output logic                 err_timeout,
`endif
  output logic [15:0]          done_count
);

  state_e      state_q, state_d;
  instr_t      cur_q, cur_d;
  logic        use_src1_q, use_src1_d;
  logic        start_q, start_d;
  logic        op_done_q, op_done_d;
  logic        err_illegal_q, err_illegal_d;
  logic [15:0] done_count_q, done_count_d;

  instr_t      push_instr;
  instr_t      fifo_head;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;

`ifdef OP_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_timeout_q, err_timeout_d;
`endif

  assign push_instr = '{op: fu_e'(instr_op), src0: instr_src0, src1: instr_src1, dst: instr_dst};

  op_fifo #(
    .QDEPTH  (QDEPTH),
    .instr_t (instr_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (instr_valid && instr_ready),
    .push_data (push_instr),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    use_src1_d    = use_src1_q;
    start_d       = 1'b0;
    op_done_d     = 1'b0;
    err_illegal_d = err_illegal_q;
    done_count_d  = done_count_q;
    fifo_pop      = 1'b0;
`ifdef OP_SEQ_TIMEOUT_EN
    wd_d          = '0;
    err_timeout_d = err_timeout_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (fifo_head.op == FU_ILLEGAL) begin
            err_illegal_d = 1'b1;
          end else begin
            cur_d      = fifo_head;
            use_src1_d = uses_src1(fifo_head.op);
            state_d    = ST_WAIT_RF;
          end
        end
      end
      ST_WAIT_RF: begin
        if (register_file_ready) begin
          start_d = 1'b1;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (destination_valid && destination_last) begin
          state_d      = ST_IDLE;
          op_done_d    = 1'b1;
          done_count_d = done_count_q + 16'd1;
        end
`ifdef OP_SEQ_TIMEOUT_EN
        // Completion wins over a watchdog expiry landing on the same cycle.
        else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = ST_IDLE;
          err_timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cur_q         <= '0;
      use_src1_q    <= 1'b0;
      start_q       <= 1'b0;
      op_done_q     <= 1'b0;
      err_illegal_q <= 1'b0;
      done_count_q  <= '0;
`ifdef OP_SEQ_TIMEOUT_EN
      wd_q          <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      use_src1_q    <= use_src1_d;
      start_q       <= start_d;
      op_done_q     <= op_done_d;
      err_illegal_q <= err_illegal_d;
      done_count_q  <= done_count_d;
`ifdef OP_SEQ_TIMEOUT_EN
      wd_q          <= wd_d;
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  assign instr_ready                = !fifo_full;
  assign busy                       = (state_q != ST_IDLE) || !fifo_empty;
  assign start_operation            = start_q;
  assign op_done                    = op_done_q;
  assign err_illegal                = err_illegal_q;
  assign done_count                 = done_count_q;
  assign use_source1                = use_src1_q;
  assign fu_sel                     = cur_q.op;
  assign source0_register_index     = cur_q.src0;
  assign source1_register_index     = cur_q.src1;
  assign destination_register_index = cur_q.dst;
`ifdef OP_SEQ_TIMEOUT_EN
  assign err_timeout                = err_timeout_q;
`endif

endmodule

// File: tb/tb_op_sequencer.sv
// Directed self-checking bench for op_sequencer; define OP_SEQ_TIMEOUT_EN to
// also exercise the watchdog.
module tb_op_sequencer;
  import cpu_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 instr_valid = 1'b0;
  logic                 instr_ready;
  logic [1:0]           instr_op = '0;
  logic [REG_IDX_W-1:0] instr_src0 = '0;
  logic [REG_IDX_W-1:0] instr_src1 = '0;
  logic [REG_IDX_W-1:0] instr_dst = '0;
  logic                 register_file_ready = 1'b0;
  logic                 destination_valid = 1'b0;
  logic                 destination_last = 1'b0;
  logic                 start_operation;
  logic                 use_source1;
  logic [1:0]           fu_sel;
  logic [REG_IDX_W-1:0] source0_register_index;
  logic [REG_IDX_W-1:0] source1_register_index;
  logic [REG_IDX_W-1:0] destination_register_index;
  logic                 busy;
  logic                 op_done;
  logic                 err_illegal;
  logic [15:0]          done_count;
`ifdef OP_SEQ_TIMEOUT_EN
  logic                 err_timeout;
`endif

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int done_cnt = 0;

  op_sequencer #(
    .QDEPTH         (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .instr_valid                (instr_valid),
    .instr_ready                (instr_ready),
    .instr_op                   (instr_op),
    .instr_src0                 (instr_src0),
    .instr_src1                 (instr_src1),
    .instr_dst                  (instr_dst),
    .register_file_ready        (register_file_ready),
    .destination_valid          (destination_valid),
    .destination_last           (destination_last),
    .start_operation            (start_operation),
    .use_source1                (use_source1),
    .fu_sel                     (fu_sel),
    .source0_register_index     (source0_register_index),
    .source1_register_index     (source1_register_index),
    .destination_register_index (destination_register_index),
    .busy                       (busy),
    .op_done                    (op_done),
    .err_illegal                (err_illegal),
`ifdef OP_SEQ_TIMEOUT_EN
    .err_timeout                (err_timeout),
`endif
    .done_count                 (done_count)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, also active through reset.
  always @(negedge clk) begin
    if (start_operation) start_cnt++;
    if (op_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset_n             = 1'b0;
    instr_valid         = 1'b0;
    register_file_ready = 1'b0;
    destination_valid   = 1'b0;
    destination_last    = 1'b0;
    step();
    step();
    check({tag, "_rst_ready"}, instr_ready, 1);
    check({tag, "_rst_busy"}, busy, 0);
    check({tag, "_rst_start"}, start_operation, 0);
    check({tag, "_rst_done"}, op_done, 0);
    check({tag, "_rst_err"}, err_illegal, 0);
    check({tag, "_rst_count"}, done_count, 0);
    check({tag, "_rst_fu"}, fu_sel, 0);
    check({tag, "_rst_use1"}, use_source1, 0);
    reset_n = 1'b1;
  endtask

  task automatic push(input logic [1:0] op, input int s0, input int s1, input int d);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_src0  = REG_IDX_W'(s0);
    instr_src1  = REG_IDX_W'(s1);
    instr_dst   = REG_IDX_W'(d);
    step();
    instr_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int budget);
    bit seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      step();
      if (start_operation) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_start_seen"}, seen, 1);
  endtask

  task automatic complete(input string tag, input int exp_count);
    destination_valid = 1'b1;
    destination_last  = 1'b1;
    step();
    destination_valid = 1'b0;
    destination_last  = 1'b0;
    check({tag, "_op_done"}, op_done, 1);
    check({tag, "_done_count"}, done_count, exp_count);
    step();
    check({tag, "_op_done_drop"}, op_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int s0;
    int d0;
    logic [REG_IDX_W-1:0] exp_dst [5];

    // Single ADD with the register file ready.
    do_reset("t1");
    register_file_ready = 1'b1;
    s0 = start_cnt;
    d0 = done_cnt;
    push(FU_ADD, 0, 1, 2);
    wait_start("t1", 6);
    check("t1_fu_sel", fu_sel, 0);
    check("t1_use1", use_source1, 1);
    check("t1_src0", source0_register_index, 0);
    check("t1_src1", source1_register_index, 1);
    check("t1_dst", destination_register_index, 2);
    check("t1_busy", busy, 1);
    step();
    check("t1_start_one_cycle", start_operation, 0);
    repeat (3) step();
    complete("t1", 1);
    step();
    check("t1_start_pulses", start_cnt - s0, 1);
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_idle", busy, 0);

    // NTT stalled on the register file; stray writeback strobes are ignored.
    do_reset("t2");
    s0 = start_cnt;
    push(FU_NTT, 3, 0, 4);
    destination_valid = 1'b1;
    destination_last  = 1'b1;
    repeat (10) step();
    destination_valid = 1'b0;
    destination_last  = 1'b0;
    check("t2_no_start", start_cnt - s0, 0);
    check("t2_busy", busy, 1);
    check("t2_no_count", done_count, 0);
    register_file_ready = 1'b1;
    wait_start("t2", 4);
    check("t2_use1", use_source1, 0);
    check("t2_fu_sel", fu_sel, 2);
    check("t2_src0", source0_register_index, 3);
    check("t2_dst", destination_register_index, 4);
    complete("t2", 1);

    // Fill the queue behind a stalled operation; the fifth push bounces.
    do_reset("t3");
    s0 = start_cnt;
    push(FU_MUL, 1, 2, 7);
    repeat (2) step();
    for (int i = 0; i < 5; i++) begin
      instr_valid = 1'b1;
      instr_op    = (i % 2 == 1) ? FU_MUL : FU_ADD;
      instr_src0  = REG_IDX_W'(i);
      instr_src1  = REG_IDX_W'(i + 1);
      instr_dst   = REG_IDX_W'(i + 1);
      check("t3_ready_before_push", instr_ready, (i < 4) ? 1 : 0);
      step();
    end
    instr_valid = 1'b0;
    check("t3_ready_full", instr_ready, 0);
    exp_dst = '{3'd7, 3'd1, 3'd2, 3'd3, 3'd4};
    register_file_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_start("t3", 6);
      check("t3_order_dst", destination_register_index, exp_dst[k]);
      complete("t3", k + 1);
    end
    repeat (4) step();
    check("t3_drained", busy, 0);
    check("t3_start_pulses", start_cnt - s0, 5);
    check("t3_ready_again", instr_ready, 1);

    // Illegal opcode is discarded and flagged; the following MUL issues.
    do_reset("t4");
    register_file_ready = 1'b1;
    s0 = start_cnt;
    push(FU_ILLEGAL, 1, 1, 1);
    push(FU_MUL, 5, 6, 7);
    check("t4_err_illegal", err_illegal, 1);
    wait_start("t4", 6);
    check("t4_fu_sel", fu_sel, 1);
    check("t4_use1", use_source1, 1);
    check("t4_src0", source0_register_index, 5);
    check("t4_src1", source1_register_index, 6);
    check("t4_dst", destination_register_index, 7);
    complete("t4", 1);
    check("t4_err_sticky", err_illegal, 1);
    check("t4_start_pulses", start_cnt - s0, 1);

    // Reset in WAIT_DONE with two instructions queued.
    do_reset("t5");
    register_file_ready = 1'b1;
    push(FU_ADD, 1, 2, 3);
    wait_start("t5", 6);
    push(FU_MUL, 2, 3, 4);
    push(FU_NTT, 4, 0, 5);
    check("t5_busy_before", busy, 1);
    s0 = start_cnt;
    d0 = done_cnt;
    #3;
    reset_n = 1'b0;
    #1;
    check("t5_busy_in_reset", busy, 0);
    check("t5_ready_in_reset", instr_ready, 1);
    check("t5_start_in_reset", start_operation, 0);
    step();
    step();
    reset_n = 1'b1;
    destination_valid = 1'b1;
    destination_last  = 1'b1;
    repeat (6) step();
    destination_valid = 1'b0;
    destination_last  = 1'b0;
    check("t5_busy_after", busy, 0);
    check("t5_no_start", start_cnt - s0, 0);
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_count", done_count, 0);

`ifdef OP_SEQ_TIMEOUT_EN
    // Watchdog aborts after 16 WAIT_DONE cycles; the next op then issues.
    do_reset("t6");
    register_file_ready = 1'b1;
    push(FU_ADD, 0, 1, 1);
    push(FU_MUL, 2, 3, 2);
    wait_start("t6", 6);
    d0 = done_cnt;
    repeat (15) step();
    check("t6_not_yet", err_timeout, 0);
    step();
    check("t6_err_timeout", err_timeout, 1);
    wait_start("t6_next", 6);
    check("t6_next_dst", destination_register_index, 2);
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_no_count", done_count, 0);
    complete("t6", 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/op_sequencer.md
OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 Parameter QDEPTH, default 4, instruction queue depth, power of two, minimum 2.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, watchdog limit in cycles; used only when OP_SEQ_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 instr_valid  input  1  an instruction is offered.
REQ-006 instr_ready  output  1  queue can accept; equals not-full.
REQ-007 instr_op  input  2  0=ADD, 1=MUL, 2=NTT, 3=illegal.
REQ-008 instr_src0, instr_src1, instr_dst  input  $clog2(NREG) each  register indices.
REQ-009 register_file_ready  input  1  regfile can accept a new operation.
REQ-010 destination_valid, destination_last  input  1 each  writeback stream observed from the FU mux.
REQ-011 start_operation  output  1  one-cycle kick to regfile.
REQ-012 use_source1  output  1  1 for ADD/MUL, 0 for NTT.
REQ-013 fu_sel  output  2  FU select; same encoding as instr_op.
REQ-014 source0_register_index, source1_register_index, destination_register_index  output  $clog2(NREG) each.
REQ-015 busy  output  1  high when state is not IDLE or the queue is non-empty.
REQ-016 op_done  output  1  one-cycle pulse per completed operation.
REQ-017 err_illegal  output  1  sticky; set when an illegal opcode is dequeued.
REQ-018 done_count  output  16  completed-operation counter; wraps 0xFFFF->0.

Function
REQ-019 A push occurs when instr_valid and instr_ready are both high; the instruction is written at the queue tail.
REQ-020 States SHALL be IDLE, WAIT_RF and WAIT_DONE.
REQ-021 IDLE with the queue non-empty: pop the head into the current-op registers and go to WAIT_RF on the next cycle.
REQ-022 A popped opcode 3 SHALL be discarded: set err_illegal, remain in IDLE, issue no start_operation.
REQ-023 WAIT_RF with register_file_ready high: start_operation is high for exactly the next cycle, then go to WAIT_DONE.
REQ-024 fu_sel, use_source1 and all index outputs SHALL stay stable from pop until the operation's op_done.
REQ-025 WAIT_DONE with destination_valid and destination_last both high: go to IDLE, pulse op_done the next cycle, and increment done_count.
REQ-026 Minimum issue-to-issue spacing is 3 cycles: IDLE pop, WAIT_RF kick, WAIT_DONE completion.
REQ-027 Push and pop in the same cycle SHALL both succeed, including when the queue is full; occupancy is unchanged.
REQ-028 A push while full (instr_ready low) SHALL be ignored and the queue contents left unchanged.
REQ-029 Queue pointers SHALL wrap modulo QDEPTH; full and empty are distinguished by an extra pointer bit.
REQ-030 destination_valid and destination_last outside WAIT_DONE SHALL be ignored.

Reset
REQ-031 While reset_n is low:
- state = IDLE;
- queue empty;
- all outputs 0, except instr_ready = 1;
- err_illegal and done_count cleared.
REQ-032 Reset asserted mid-operation SHALL abandon the current operation and all queued instructions; no op_done is produced.

Configuration
REQ-033 With OP_SEQ_TIMEOUT_EN defined:
- a watchdog counts cycles in WAIT_DONE;
- at TIMEOUT_CYCLES it forces IDLE and sets sticky output err_timeout (1 bit);
- no op_done and no done_count increment for the aborted operation.
REQ-034 Without OP_SEQ_TIMEOUT_EN, the err_timeout port and the watchdog counter SHALL be absent; WAIT_DONE waits indefinitely.

Structure
REQ-035 Shared package cpu_pkg SHALL hold NREG, the opcode enum fu_e, the state enum and the packed instr_t {op, src0, src1, dst}.
REQ-036 The queue SHALL be a sub-module op_fifo with parameters QDEPTH and type instr_t, providing push/pop/full/empty.

Verification
REQ-037 Push ADD src0=0 src1=1 dst=2 with register_file_ready=1, then drive last 5 cycles after start -> one start_operation pulse, fu_sel=0, use_source1=1, op_done once, done_count=1.
REQ-038 Push NTT src0=3 dst=4 with register_file_ready low for 10 cycles -> start_operation only after ready rises, use_source1=0.
REQ-039 Push 5 instructions back-to-back with QDEPTH=4 and the first operation stalled -> instr_ready low after 4 pushes, 5th ignored, 4 ops complete in FIFO order.
REQ-040 Push op=3, then MUL -> err_illegal=1, MUL issues normally, done_count=1.
REQ-041 Assert reset_n low during WAIT_DONE with 2 instructions queued -> busy=0, queue empty, no op_done.
REQ-042 With OP_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, never drive last -> err_timeout=1 after 16 WAIT_DONE cycles, state IDLE, next queued op issues.
